seg7_bcd_counter: RTL

//  Parametrised multi-digit BCD counter with a multiplexed 7-segment display driver.

---
 rtl/seg7_bcd_counter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_counter.sv
// Multi-digit BCD up/down counter with load, wrap pulse and
// a multiplexed 7-segment scan driver.
module seg7_bcd_counter #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SCAN_DIV       = 50_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     ga
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic          POL       = (SEG_ACTIVE_LOW != 0);

  logic [DIGITS-1:0][3:0] cnt;
  logic [DIGITS-1:0][3:0] nxt;
  logic [DIGITS-1:0][3:0] ld;
  logic [PW-1:0]          pre;
  logic [SW-1:0]          scan_cnt;
  logic [IW-1:0]          scan_idx;
  logic                   tick;
  logic                   ripple;
  logic                   wrap;
  logic [DIGITS-1:0]      onehot;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign tick   = en && (pre == PRE_LAST);
  assign bcd    = cnt;
  assign onehot = DIGITS'(1) << scan_idx;

  // Ripple increment/decrement across digits; wrap when all roll over.
  always_comb begin
    nxt    = cnt;
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (up) begin
          if (cnt[i] == 4'd9) begin
            nxt[i] = 4'd0;
          end else begin
            nxt[i] = cnt[i] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'd0) begin
            nxt[i] = 4'd9;
          end else begin
            nxt[i] = cnt[i] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    wrap = ripple;
  end

  // Clamp out-of-range load nibbles to 9.
  always_comb begin
    ld = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        ld[i] = 4'd9;
      end else begin
        ld[i] = load_val[4*i +: 4];
      end
    end
  end

  // Tick prescaler: holds while disabled, cleared by load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (load) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  // Count register and wrap pulse; load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      cnt   <= ld;
      carry <= 1'b0;
    end else if (tick) begin
      cnt   <= nxt;
      carry <= wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  // Free-running digit scan position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Anode and segments registered together so they switch in step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ga  <= DIGITS'(1) ^ {DIGITS{POL}};
      seg <= 7'h3F ^ {7{POL}};
    end else begin
      ga  <= onehot ^ {DIGITS{POL}};
      seg <= glyph(cnt[scan_idx]) ^ {7{POL}};
    end
  end

endmodule
